// File: rtl/agex_sequencer.sv
// agex_sequencer: control sequencer for a small x86-like address-generate /
// execute datapath. It accepts one decoded instruction at a time and walks it
// through address generation, memory wait, ALU execute, register writeback
// and EIP update. Every datapath control is decoded combinationally from the
// current state and the captured instruction fields.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   instruction handshake (ready only while idle)
//   op, mod, disp_sz      instruction class, ModRM mod field, disp8/disp32
//   mem_req / mem_ack     memory read request / read data valid
//   gate_*                MEM_BUS drivers (at most one active per cycle)
//   en_eip, eip_mux_s, eip_disp_mux_s   EIP register load and source selects
//   en_alu_shf, alu_shf_mux_s           ALU shift/operand register load
//   sr1_mux_s, sr2_mux_s, aluk, dr_we   ALU operand selects, ALU op, reg write
//   done                  one-cycle retire pulse
//   err                   sticky memory-timeout flag
//
// Build option
//   AGEX_SEQ_TIMEOUT_EN   when defined, a memory wait that reaches its 16th
//                         cycle without mem_ack sets err and abandons the
//                         instruction. When undefined, the wait is unbounded
//                         and err is tied low.
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready high
// AGEN  | effective address on the bus, first memory request cycle
// MWAIT | memory request held until mem_ack
// EXEC  | ALU operands and function selected
// WB    | ALU result gated onto the bus, destination register written
// EIPU  | EIP updated, instruction retires

module agex_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] op,
   input  logic [1:0] mod,
   input  logic       disp_sz,
   output logic       mem_req,
   input  logic       mem_ack,
   output logic       gate_eip,
   output logic       gate_sr1,
   output logic       gate_addr_gen,
   output logic       gate_alu,
   output logic       en_eip,
   output logic [1:0] eip_mux_s,
   output logic [1:0] eip_disp_mux_s,
   output logic       en_alu_shf,
   output logic [1:0] alu_shf_mux_s,
   output logic       sr1_mux_s,
   output logic [1:0] sr2_mux_s,
   output logic [1:0] aluk,
   output logic       dr_we,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      AGEN  = 3'd1,
      MWAIT = 3'd2,
      EXEC  = 3'd3,
      WB    = 3'd4,
      EIPU  = 3'd5
   } state_t;

   localparam logic [2:0] OP_ADD_RR  = 3'b000;
   localparam logic [2:0] OP_ADD_I32 = 3'b001;
   localparam logic [2:0] OP_ADD_I8  = 3'b010;
   localparam logic [2:0] OP_OR_RR   = 3'b011;
   localparam logic [2:0] OP_SHR_I8  = 3'b100;
   localparam logic [2:0] OP_JMP_REL = 3'b101;
   localparam logic [2:0] OP_JMP_RM  = 3'b110;
   localparam logic [2:0] OP_ADD_RM  = 3'b111;

   state_t     state, state_nx;
   logic [2:0] op_q;
   logic [1:0] mod_q;
   logic       disp_sz_q;
   logic       timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= 3'b000;
         mod_q     <= 2'b00;
         disp_sz_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            op_q      <= op;
            mod_q     <= mod;
            disp_sz_q <= disp_sz;
         end
      end
   end

`ifdef AGEX_SEQ_TIMEOUT_EN
   // Down-counter loaded while in AGEN so it holds 15 on the first MWAIT
   // cycle; reaching zero marks the 16th wait cycle.
   logic [3:0] wait_cnt;
   logic       err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         if (state == AGEN) begin
            wait_cnt <= 4'hF;
         end else if (state == MWAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (timeout) begin
            err_q <= 1'b1;
         end
      end
   end

   // An ack on the terminal cycle wins over the timeout.
   assign timeout = (state == MWAIT) && !mem_ack && (wait_cnt == 4'd0);
   assign err     = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_nx       = state;
      in_ready       = 1'b0;
      mem_req        = 1'b0;
      gate_eip       = 1'b0;
      gate_sr1       = 1'b0;
      gate_addr_gen  = 1'b0;
      gate_alu       = 1'b0;
      en_eip         = 1'b0;
      eip_mux_s      = 2'b00;
      eip_disp_mux_s = 2'b00;
      en_alu_shf     = 1'b0;
      alu_shf_mux_s  = 2'b00;
      sr1_mux_s      = 1'b0;
      sr2_mux_s      = 2'b00;
      aluk           = 2'b00;
      dr_we          = 1'b0;
      done           = 1'b0;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            // Routing is decided from the live fields on the accept edge.
            if (in_valid) begin
               case (op)
                  OP_JMP_REL: state_nx = EIPU;
                  OP_JMP_RM:  state_nx = (mod == 2'b11) ? EIPU : AGEN;
                  OP_ADD_RM:  state_nx = AGEN;
                  default:    state_nx = EXEC;
               endcase
            end
         end

         AGEN: begin
            gate_addr_gen = 1'b1;
            mem_req       = 1'b1;
            state_nx      = MWAIT;
         end

         MWAIT: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               if (op_q == OP_ADD_RM) begin
                  en_alu_shf    = 1'b1;
                  alu_shf_mux_s = 2'b11;
                  state_nx      = EXEC;
               end else begin
                  // Indirect jump through memory retires on the ack itself.
                  en_eip    = 1'b1;
                  eip_mux_s = 2'b11;
                  done      = 1'b1;
                  state_nx  = IDLE;
               end
            end else if (timeout) begin
               state_nx = IDLE;
            end
         end

         EXEC: begin
            sr1_mux_s = 1'b0;
            case (op_q)
               OP_ADD_I32: sr2_mux_s = 2'b01;
               OP_ADD_I8:  sr2_mux_s = 2'b10;
               OP_SHR_I8:  sr2_mux_s = 2'b10;
               OP_ADD_RM:  sr2_mux_s = 2'b11;
               default:    sr2_mux_s = 2'b00;
            endcase
            case (op_q)
               OP_OR_RR:  aluk = 2'b01;
               OP_SHR_I8: aluk = 2'b11;
               default:   aluk = 2'b00;
            endcase
            state_nx = WB;
         end

         WB: begin
            gate_alu = 1'b1;
            dr_we    = 1'b1;
            state_nx = EIPU;
         end

         EIPU: begin
            en_eip = 1'b1;
            done   = 1'b1;
            if (op_q == OP_JMP_REL) begin
               eip_disp_mux_s = disp_sz_q ? 2'b11 : 2'b10;
            end else if (op_q == OP_JMP_RM && mod_q == 2'b11) begin
               eip_mux_s = 2'b01;
            end
            state_nx = IDLE;
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule
